vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. It produces a pixel-rate strobe, pixel coordinates, an active-video flag and registered HS/VS. It sits directly upstream of `SnowGenerator` and the other pixel generators, which consume `pix_en`, `hcount`, `vcount` and `active` to drive `red`/`green`/`blue`. Its HS/VS are routed to the connector pins.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; legal range 1..16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `pix_en`  out  1: one-`clk` strobe, once every `CLK_DIV` clocks.
- `hcount`  out  10: current pixel column, 0..H_TOTAL-1.
- `vcount`  out  10: current line, 0..V_TOTAL-1.
- `active`  out  1: high while `hcount<H_ACTIVE` and `vcount<V_ACTIVE`.
- `HS`  out  1: horizontal sync, active-low.
- `VS`  out  1: vertical sync, active-low.
- `line_start`  out  1: high while `hcount==0`.
- `frame_start`  out  1: high while `hcount==0` and `vcount==0`.

## Operation
- Derived totals:
  - `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`, 800 with defaults.
  - `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP`, 525 with defaults.
- Divider counter `div` counts 0..CLK_DIV-1 and wraps. `pix_en` is high exactly in cycles where `div==CLK_DIV-1`. With `CLK_DIV==1`, `pix_en` is constantly high out of reset.
- Counter stepping, only on a rising edge where `pix_en==1`:
  - `hcount` increments.
  - At `H_TOTAL-1`, `hcount` wraps to 0 and `vcount` increments.
  - When `vcount` is at `V_TOTAL-1` and `hcount` wraps, `vcount` also wraps to 0.
- Decoded outputs are registered and updated on the same edge as the counters, so they always match the current `hcount`/`vcount`:
  - `HS`=0 iff `hcount` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; default [656,751].
  - `VS`=0 iff `vcount` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; default [490,491].
  - `active`, `line_start` and `frame_start` as defined in the port list.
- Reset values, applied asynchronously:
  - `div`=0, `pix_en`=0.
  - `hcount`=H_TOTAL-1 (799), `vcount`=V_TOTAL-1 (524).
  - `active`=0, `HS`=1, `VS`=1, `line_start`=0, `frame_start`=0.
  - These values are self-consistent: they describe the last blanking pixel. The first `pix_en` edge therefore enters (0,0) cleanly.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no clock required. After release, the start-up sequence restarts exactly as after power-on.
- No glitches on HS/VS: both come straight from flops, never from combinational decode.

## Timing
- After `rst_n` rises, `pix_en` is first high after `CLK_DIV-1` rising edges. The default first strobe is after edge 3.
- The next edge (edge `CLK_DIV`, edge 4 by default) moves the counters to (0,0). On that edge `active`, `line_start` and `frame_start` go high.
- Sync timing, defaults:
  - HS low width: 96 pixels = 384 `clk`.
  - Line period: 3200 `clk`.
  - VS low width: 2 lines = 6400 `clk`.
  - Frame period: 1,680,000 `clk` (16.8 ms).
- `active` is high for 640 consecutive pixels per visible line, 307,200 pixels per frame.
- `frame_start` and `line_start` are high for one pixel period, `CLK_DIV` clocks. Consumers qualify them with `pix_en`.
- Downstream latency contract: a generator sampling coordinates on a `pix_en` edge and registering RGB is one pixel late relative to HS/VS. That offset is 1 of 16 front-porch pixels and is accepted.

## Structure
- Package `vga_pkg` holds:
  - The default timing constants.
  - A function computing `H_TOTAL`, `V_TOTAL` and the sync start/end points from the parameters.
  - The coordinate width constant `VGA_CW=10`.
- Sub-module `pixel_strobe`:
  - Contains the `CLK_DIV` divider only.
  - Ports: `clk`, `rst_n`, `pix_en`.
  - Reusable by other clock-enabled video stages.
- Top level holds the h/v counters and the registered decode.

## Test plan
- Reset state:
  - Hold `rst_n`=0 and toggle `clk` → `hcount`=799, `vcount`=524, HS=VS=1, `active`=0, `pix_en`=0.
  - Pulse `rst_n` low between clock edges → outputs change without a clock edge.
- Start-up:
  - Release reset → `pix_en` first high after 3 edges.
  - Edge 4 → (0,0) with `active`, `line_start` and `frame_start` all 1.
  - `pix_en` period is exactly 4 clocks thereafter.
- Horizontal timing:
  - Run one line → HS falls when `hcount` becomes 656 and rises at 752.
  - `active` falls at `hcount` 640.
  - `line_start` repeats every 3200 clocks.
- Frame timing:
  - Run 2 frames → VS low for lines 490–491 only.
  - `frame_start` period is 1,680,000 clocks.
  - Count of `pix_en`&`active` per frame is 307,200.
  - `vcount` wraps 524→0.
- Mid-frame reset:
  - Assert `rst_n`=0 at (300,200) → immediate reset values.
  - After release, the start-up sequence repeats exactly.
- Divider parameter:
  - With `CLK_DIV`=1 → `pix_en` constantly 1 and line period 800 clocks.
  - With `CLK_DIV`=2 → line period 1600 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA timing constants and derived-timing helper.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int VGA_CW       = 10;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef struct packed {
        int unsigned h_total;
        int unsigned v_total;
        int unsigned hs_start;
        int unsigned hs_end;
        int unsigned vs_start;
        int unsigned vs_end;
    } vga_timing_t;

    // Sync windows are inclusive: [start, end].
    function automatic vga_timing_t vga_calc_timing(
        input int unsigned h_active, input int unsigned h_fp,
        input int unsigned h_sync,   input int unsigned h_bp,
        input int unsigned v_active, input int unsigned v_fp,
        input int unsigned v_sync,   input int unsigned v_bp
    );
        vga_timing_t t;
        t.h_total  = h_active + h_fp + h_sync + h_bp;
        t.v_total  = v_active + v_fp + v_sync + v_bp;
        t.hs_start = h_active + h_fp;
        t.hs_end   = h_active + h_fp + h_sync - 1;
        t.vs_start = v_active + v_fp;
        t.vs_end   = v_active + v_fp + v_sync - 1;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Raster timing bundle from the timing generator to pixel stages.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic              pix_en;
    logic [VGA_CW-1:0] hcount;
    logic [VGA_CW-1:0] vcount;
    logic              active;
    logic              HS;
    logic              VS;
    logic              line_start;
    logic              frame_start;

    modport master (
        output pix_en, hcount, vcount, active, HS, VS, line_start, frame_start
    );

    modport slave (
        input  pix_en, hcount, vcount, active, HS, VS, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/pixel_strobe.sv
`default_nettype none
// ============================================================================
// Module   : pixel_strobe
// Brief    : Divides the system clock into a one-cycle pixel-rate enable.
// Revision : 1.0
// ============================================================================
module pixel_strobe #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      pix_en
);
    localparam int              c_DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DW-1:0] c_LAST = c_DW'(CLK_DIV - 1);

    logic [c_DW-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == c_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Gating with rst_n keeps the strobe low in reset even when CLK_DIV==1,
    // where the divider is permanently at its terminal count.
    assign pix_en = rst_n && (r_div == c_LAST);
endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA raster counters with registered sync/flag decode.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    vga_timing_gen_if.master   vif
);
    localparam vga_timing_t c_T = vga_calc_timing(H_ACTIVE, H_FP, H_SYNC, H_BP,
                                                   V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [VGA_CW-1:0] c_H_LAST   = VGA_CW'(c_T.h_total - 1);
    localparam logic [VGA_CW-1:0] c_V_LAST   = VGA_CW'(c_T.v_total - 1);
    localparam logic [VGA_CW-1:0] c_H_ACT    = VGA_CW'(H_ACTIVE);
    localparam logic [VGA_CW-1:0] c_V_ACT    = VGA_CW'(V_ACTIVE);
    localparam logic [VGA_CW-1:0] c_HS_START = VGA_CW'(c_T.hs_start);
    localparam logic [VGA_CW-1:0] c_HS_END   = VGA_CW'(c_T.hs_end);
    localparam logic [VGA_CW-1:0] c_VS_START = VGA_CW'(c_T.vs_start);
    localparam logic [VGA_CW-1:0] c_VS_END   = VGA_CW'(c_T.vs_end);

    logic              w_pix_en;
    logic              w_h_wrap;
    logic [VGA_CW-1:0] w_h_nxt;
    logic [VGA_CW-1:0] w_v_nxt;

    logic [VGA_CW-1:0] r_hcount;
    logic [VGA_CW-1:0] r_vcount;
    logic              r_active;
    logic              r_hs;
    logic              r_vs;
    logic              r_line_start;
    logic              r_frame_start;

    pixel_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (w_pix_en)
    );

    always_comb begin
        w_h_wrap = (r_hcount == c_H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_hcount + 1'b1;
        w_v_nxt  = r_vcount;
        if (w_h_wrap) begin
            w_v_nxt = (r_vcount == c_V_LAST) ? '0 : r_vcount + 1'b1;
        end
    end

    // Decode from the next coordinates so the flags land on the same edge as
    // the counters and always describe the pixel currently presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= c_H_LAST;
            r_vcount      <= c_V_LAST;
            r_active      <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_pix_en) begin
            r_hcount      <= w_h_nxt;
            r_vcount      <= w_v_nxt;
            r_active      <= (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
            r_hs          <= !((w_h_nxt >= c_HS_START) && (w_h_nxt <= c_HS_END));
            r_vs          <= !((w_v_nxt >= c_VS_START) && (w_v_nxt <= c_VS_END));
            r_line_start  <= (w_h_nxt == '0);
            r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign vif.pix_en      = w_pix_en;
    assign vif.hcount      = r_hcount;
    assign vif.vcount      = r_vcount;
    assign vif.active      = r_active;
    assign vif.HS          = r_hs;
    assign vif.VS          = r_vs;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomized reset/run bench for vga_timing_gen against a raster model.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint n_edges = 0;
    int     n_total = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if u_if_dflt ();
    vga_timing_gen_if u_if_d1 ();
    vga_timing_gen_if u_if_d2 ();

    vga_timing_gen u_dut_dflt (.clk(clk), .rst_n(rst_n), .vif(u_if_dflt));

    vga_timing_gen #(
        .CLK_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_d1 (.clk(clk), .rst_n(rst_n), .vif(u_if_d1));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut_d2 (.clk(clk), .rst_n(rst_n), .vif(u_if_d2));

    // Rising edges seen since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Closed-form raster position: n edges give n/cd pixel steps from the
    // last blanking pixel, so the pixel index is a simple modular offset.
    function automatic logic [31:0] model(
        input int cd, input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp,
        input bit in_rst, input longint n
    );
        int     ht, vt, h, v;
        longint lin;
        bit     pe, act, hsn, vsn;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (in_rst) begin
            h  = ht - 1;
            v  = vt - 1;
            pe = 1'b0;
        end else begin
            pe  = ((n % cd) == longint'(cd - 1));
            lin = (longint'(ht) * vt - 1 + n / cd) % (longint'(ht) * vt);
            h   = int'(lin % ht);
            v   = int'(lin / ht);
        end
        act = (h < ha) && (v < va);
        hsn = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        vsn = !((v >= va + vfp) && (v < va + vfp + vsw));
        return {6'd0, pe, 10'(h), 10'(v), act, hsn, vsn, (h == 0), (h == 0) && (v == 0)};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_dflt"},
            {6'd0, u_if_dflt.pix_en, u_if_dflt.hcount, u_if_dflt.vcount, u_if_dflt.active,
             u_if_dflt.HS, u_if_dflt.VS, u_if_dflt.line_start, u_if_dflt.frame_start},
            model(4, 640, 16, 96, 48, 480, 10, 2, 33, !rst_n, n_edges));
        chk({tag, "_d1"},
            {6'd0, u_if_d1.pix_en, u_if_d1.hcount, u_if_d1.vcount, u_if_d1.active,
             u_if_d1.HS, u_if_d1.VS, u_if_d1.line_start, u_if_d1.frame_start},
            model(1, 640, 16, 96, 48, 4, 1, 1, 1, !rst_n, n_edges));
        chk({tag, "_d2"},
            {6'd0, u_if_d2.pix_en, u_if_d2.hcount, u_if_d2.vcount, u_if_d2.active,
             u_if_d2.HS, u_if_d2.VS, u_if_d2.line_start, u_if_d2.frame_start},
            model(2, 20, 3, 4, 5, 10, 2, 2, 3, !rst_n, n_edges));
    endtask

    always @(negedge clk) check_all("cyc");

    // Frame-level accounting on the small CLK_DIV=2 raster: 20x10 visible
    // pixels and 32*17*2 clocks per frame.
    int     fr_cnt = 0;
    longint fr_cyc = 0;
    longint fr_last = 0;
    bit     fr_armed = 1'b0;

    always @(negedge clk) begin
        fr_cyc++;
        if (!rst_n) begin
            fr_armed = 1'b0;
            fr_cnt   = 0;
        end else if (u_if_d2.pix_en) begin
            if (u_if_d2.frame_start) begin
                if (fr_armed) begin
                    chk("d2_frame_active", fr_cnt, 200);
                    chk("d2_frame_period", 32'(fr_cyc - fr_last), 1088);
                end
                fr_armed = 1'b1;
                fr_cnt   = 0;
                fr_last  = fr_cyc;
            end
            if (u_if_d2.active) fr_cnt++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all("hold_rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12000) @(posedge clk);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(200, 3000)) @(posedge clk);
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1;
            check_all("async_rst");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b1;
        end

        repeat (2500) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
